// File: rtl/rcu_pll_seq.sv
// Purpose : RCU PLL sequencer. Powers the PLL, qualifies lock, then moves the core/HF
//           clock mux between bypass (LFOSC) and PLL with a gate -> switch -> ungate
//           sequence. The PLL-domain reset is held throughout the switch.
// Latency : all outputs registered; one reference-clock cycle per state step.
//           Lock is seen 2 cycles late through the synchronizer.
// Backpressure: none. pll_req_i is a level. It is sampled only in IDLE, WAIT_LOCK and RUN.
// Ports   : clk_i/rst_i (async active-high); pll_req_i, pll_lock_i (async), err_clr_i;
//           pll_en_o, clk_gate_en_o, clk_sel_o, dom_rst_o, busy_o, run_o, err_o,
//           state_o[2:0].
// Option  : RCU_PLL_SEQ_RETRY_EN. When defined, a lock timeout drops the PLL enable
//           and retries, with up to 4 attempts in total. Only the last timeout goes
//           to FAIL.
module rcu_pll_seq #(
    parameter int LOCK_TIMEOUT = 4096,
    parameter int STABLE_CNT   = 16,
    parameter int GATE_DLY     = 4,
    parameter int CNT_WIDTH    = $clog2(LOCK_TIMEOUT + 1)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_req_i,
    input  logic       pll_lock_i,
    input  logic       err_clr_i,
    output logic       pll_en_o,
    output logic       clk_gate_en_o,
    output logic       clk_sel_o,
    output logic       dom_rst_o,
    output logic       busy_o,
    output logic       run_o,
    output logic       err_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLL_ON    = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_GATE_OFF  = 3'd3,
        ST_SWITCH    = 3'd4,
        ST_GATE_ON   = 3'd5,
        ST_RUN       = 3'd6,
        ST_FAIL      = 3'd7
    } state_e;

    localparam logic [CNT_WIDTH-1:0] TMO_MAX = CNT_WIDTH'(LOCK_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] STB_MAX = CNT_WIDTH'(STABLE_CNT);
    localparam logic [CNT_WIDTH-1:0] DLY_MAX = CNT_WIDTH'(GATE_DLY);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e               state_q, state_d;
    logic [1:0]           lock_sync_q, lock_sync_d;
    logic                 tgt_q, tgt_d;
    logic [CNT_WIDTH-1:0] tmo_q, tmo_d, stb_q, stb_d, dly_q, dly_d;
    logic [CNT_WIDTH-1:0] tmo_inc, stb_inc, dly_inc;
    logic                 pll_en_q, pll_en_d;
    logic                 gate_en_q, gate_en_d;
    logic                 clk_sel_q, clk_sel_d;
    logic                 dom_rst_q, dom_rst_d;
    logic                 busy_q, busy_d;
    logic                 run_q, run_d;
    logic                 err_q, err_d;
    logic                 err_set;
    logic                 lock_s;
`ifdef RCU_PLL_SEQ_RETRY_EN
    logic [1:0]           retry_q, retry_d;
    logic                 drop_q, drop_d;   // PLL_ON is in its enable-low retry gap
`endif

    assign lock_s = lock_sync_q[1];

    always_comb begin
        lock_sync_d = {lock_sync_q[0], pll_lock_i};
        state_d     = state_q;
        tgt_d       = tgt_q;
        tmo_d       = tmo_q;
        stb_d       = stb_q;
        dly_d       = dly_q;
        clk_sel_d   = clk_sel_q;
        err_set     = 1'b0;
        tmo_inc     = sat_inc(tmo_q);
        stb_inc     = sat_inc(stb_q);
        dly_inc     = sat_inc(dly_q);
`ifdef RCU_PLL_SEQ_RETRY_EN
        retry_d     = retry_q;
        drop_d      = drop_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef RCU_PLL_SEQ_RETRY_EN
                retry_d = 2'd0;
`endif
                if (pll_req_i && !err_q) begin
                    state_d = ST_PLL_ON;
                    tgt_d   = 1'b1;
                end
            end
            ST_PLL_ON: begin
`ifdef RCU_PLL_SEQ_RETRY_EN
                if (drop_q) begin
                    // Hold the enable low for GATE_DLY cycles. Then spend one
                    // normal PLL_ON cycle with the enable high.
                    dly_d = dly_inc;
                    if (dly_inc == DLY_MAX) begin
                        drop_d = 1'b0;
                        dly_d  = '0;
                    end
                end else
`endif
                begin
                    tmo_d   = '0;
                    stb_d   = '0;
                    dly_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                tmo_d = tmo_inc;
                stb_d = lock_s ? stb_inc : '0;
                // A dropped request wins over both lock qualification and timeout.
                if (!pll_req_i) begin
                    state_d = ST_IDLE;
                end else if (stb_d == STB_MAX) begin
                    state_d = ST_GATE_OFF;
                    dly_d   = '0;
                end else if (tmo_d == TMO_MAX) begin
`ifdef RCU_PLL_SEQ_RETRY_EN
                    if (retry_q != 2'd3) begin
                        retry_d = retry_q + 2'd1;
                        drop_d  = 1'b1;
                        dly_d   = '0;
                        state_d = ST_PLL_ON;
                    end else
`endif
                    begin
                        state_d = ST_FAIL;
                        err_set = 1'b1;
                    end
                end
            end
            ST_GATE_OFF: begin
                dly_d = dly_inc;
                if (dly_inc == DLY_MAX) begin
                    dly_d     = '0;
                    state_d   = ST_SWITCH;
                    // The gate is already low and stays low through SWITCH.
                    clk_sel_d = tgt_q;
                end
            end
            ST_SWITCH: begin
                dly_d = dly_inc;
                if (dly_inc == DLY_MAX) begin
                    dly_d   = '0;
                    state_d = ST_GATE_ON;
                end
            end
            ST_GATE_ON: begin
                dly_d = dly_inc;
                if (dly_inc == DLY_MAX) begin
                    dly_d   = '0;
                    state_d = tgt_q ? ST_RUN : ST_IDLE;
                end
            end
            ST_RUN: begin
                // Loss of lock wins over a bypass request.
                if (!lock_s) begin
                    err_set = 1'b1;
                    tgt_d   = 1'b0;
                    dly_d   = '0;
                    state_d = ST_GATE_OFF;
                end else if (!pll_req_i) begin
                    tgt_d   = 1'b0;
                    dly_d   = '0;
                    state_d = ST_GATE_OFF;
                end
            end
            ST_FAIL:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        err_d     = err_set | (err_q & ~err_clr_i);

        // Outputs are decoded from the next state so that each registered output
        // lines up with state_o.
        pll_en_d  = !(state_d inside {ST_IDLE, ST_FAIL});
`ifdef RCU_PLL_SEQ_RETRY_EN
        pll_en_d  = pll_en_d & ~drop_d;
`endif
        gate_en_d = !(state_d inside {ST_GATE_OFF, ST_SWITCH});
        dom_rst_d = state_d inside {ST_GATE_OFF, ST_SWITCH, ST_GATE_ON};
        busy_d    = !(state_d inside {ST_IDLE, ST_RUN});
        run_d     = (state_d == ST_RUN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            lock_sync_q <= 2'b00;
            tgt_q       <= 1'b0;
            tmo_q       <= '0;
            stb_q       <= '0;
            dly_q       <= '0;
            pll_en_q    <= 1'b0;
            gate_en_q   <= 1'b1;
            clk_sel_q   <= 1'b0;
            dom_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
            run_q       <= 1'b0;
            err_q       <= 1'b0;
`ifdef RCU_PLL_SEQ_RETRY_EN
            retry_q     <= 2'd0;
            drop_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lock_sync_q <= lock_sync_d;
            tgt_q       <= tgt_d;
            tmo_q       <= tmo_d;
            stb_q       <= stb_d;
            dly_q       <= dly_d;
            pll_en_q    <= pll_en_d;
            gate_en_q   <= gate_en_d;
            clk_sel_q   <= clk_sel_d;
            dom_rst_q   <= dom_rst_d;
            busy_q      <= busy_d;
            run_q       <= run_d;
            err_q       <= err_d;
`ifdef RCU_PLL_SEQ_RETRY_EN
            retry_q     <= retry_d;
            drop_q      <= drop_d;
`endif
        end
    end

    assign pll_en_o      = pll_en_q;
    assign clk_gate_en_o = gate_en_q;
    assign clk_sel_o     = clk_sel_q;
    assign dom_rst_o     = dom_rst_q;
    assign busy_o        = busy_q;
    assign run_o         = run_q;
    assign err_o         = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_rcu_pll_seq.sv
// Purpose : directed bench for rcu_pll_seq with LOCK_TIMEOUT=64, STABLE_CNT=4, GATE_DLY=2.
// Latency : expected values are hand-computed cycle positions relative to clock edges.
// Backpressure: n/a. Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_rcu_pll_seq;

    logic       clk;
    logic       rst;
    logic       pll_req;
    logic       pll_lock;
    logic       err_clr;
    logic       pll_en;
    logic       gate_en;
    logic       clk_sel;
    logic       dom_rst;
    logic       busy;
    logic       run;
    logic       err;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    rcu_pll_seq #(
        .LOCK_TIMEOUT (64),
        .STABLE_CNT   (4),
        .GATE_DLY     (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pll_req_i     (pll_req),
        .pll_lock_i    (pll_lock),
        .err_clr_i     (err_clr),
        .pll_en_o      (pll_en),
        .clk_gate_en_o (gate_en),
        .clk_sel_o     (clk_sel),
        .dom_rst_o     (dom_rst),
        .busy_o        (busy),
        .run_o         (run),
        .err_o         (err),
        .state_o       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        pll_req  = 1'b0;
        pll_lock = 1'b0;
        err_clr  = 1'b0;
        #2 rst = 1'b1;
        #10;
        check("rst_state",   32'(state),   32'd0);
        check("rst_pll_en",  32'(pll_en),  32'd0);
        check("rst_gate",    32'(gate_en), 32'd1);
        check("rst_sel",     32'(clk_sel), 32'd0);
        check("rst_dom",     32'(dom_rst), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_run",     32'(run),     32'd0);
        check("rst_err",     32'(err),     32'd0);
        step(1);
        rst = 1'b0;

        // ---- Basic switch: request at E0, lock raised after E2 ----
        pll_req = 1'b1;
        step(1);                                    // E1: PLL_ON
        check("bs_pll_on",    32'(state),  32'd1);
        check("bs_pll_en",    32'(pll_en), 32'd1);
        step(1);                                    // E2: WAIT_LOCK
        check("bs_wait",      32'(state),  32'd2);
        pll_lock = 1'b1;                            // lock_s high from E4
        step(5);                                    // E7: stable count is 3
        check("bs_wait_e7",   32'(state),  32'd2);
        check("bs_gate_e7",   32'(gate_en), 32'd1);
        step(1);                                    // E8: GATE_OFF
        check("bs_goff",      32'(state),  32'd3);
        check("bs_goff_gate", 32'(gate_en), 32'd0);
        check("bs_goff_dom",  32'(dom_rst), 32'd1);
        check("bs_goff_sel",  32'(clk_sel), 32'd0);
        step(2);                                    // E10: SWITCH
        check("bs_sw",        32'(state),  32'd4);
        check("bs_sw_sel",    32'(clk_sel), 32'd1);
        check("bs_sw_gate",   32'(gate_en), 32'd0);
        step(2);                                    // E12: GATE_ON
        check("bs_gon",       32'(state),  32'd5);
        check("bs_gon_gate",  32'(gate_en), 32'd1);
        check("bs_gon_dom",   32'(dom_rst), 32'd1);
        step(2);                                    // E14: RUN
        check("bs_run_st",    32'(state),  32'd6);
        check("bs_run",       32'(run),    32'd1);
        check("bs_run_dom",   32'(dom_rst), 32'd0);
        check("bs_run_busy",  32'(busy),   32'd0);
        check("bs_run_err",   32'(err),    32'd0);

        // ---- Requested bypass from RUN ----
        pll_req = 1'b0;
        step(1);
        check("byp_goff",     32'(state),  32'd3);
        check("byp_goff_en",  32'(pll_en), 32'd1);
        step(2);
        check("byp_sw_sel",   32'(clk_sel), 32'd0);
        check("byp_sw_en",    32'(pll_en), 32'd1);
        step(2);
        check("byp_gon",      32'(state),  32'd5);
        check("byp_gon_en",   32'(pll_en), 32'd1);
        step(2);
        check("byp_idle",     32'(state),  32'd0);
        check("byp_idle_en",  32'(pll_en), 32'd0);
        check("byp_err",      32'(err),    32'd0);

        // ---- Lock loss in RUN (lock_s already high) ----
        pll_req = 1'b1;
        step(12);                                   // PLL_ON, WAIT_LOCK x4, gates -> RUN
        check("ll_run",       32'(state),  32'd6);
        pll_lock = 1'b0;
        step(2);                                    // lock_s just fell
        check("ll_still_run", 32'(run),    32'd1);
        step(1);                                    // third edge: leave RUN
        check("ll_run_low",   32'(run),    32'd0);
        check("ll_err",       32'(err),    32'd1);
        check("ll_goff",      32'(state),  32'd3);
        step(2);
        check("ll_sw_sel",    32'(clk_sel), 32'd0);
        step(4);
        check("ll_idle",      32'(state),  32'd0);
        check("ll_idle_en",   32'(pll_en), 32'd0);
        step(3);                                    // request ignored while err set
        check("ll_hold",      32'(state),  32'd0);
        pll_req = 1'b0;
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("ll_clr",       32'(err),    32'd0);

`ifndef RCU_PLL_SEQ_RETRY_EN
        // ---- Lock timeout (lock low) ----
        pll_req = 1'b1;
        step(2);
        check("to_wait",      32'(state),  32'd2);
        step(63);
        check("to_wait_63",   32'(state),  32'd2);
        err_clr = 1'b1;                             // same cycle as set: set wins
        step(1);
        err_clr = 1'b0;
        check("to_fail",      32'(state),  32'd7);
        check("to_err",       32'(err),    32'd1);
        check("to_pll_en",    32'(pll_en), 32'd0);
        check("to_sel",       32'(clk_sel), 32'd0);
        check("to_busy",      32'(busy),   32'd1);
        step(1);
        check("to_idle",      32'(state),  32'd0);
        step(5);
        check("to_hold",      32'(state),  32'd0);
        check("to_hold_err",  32'(err),    32'd1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("to_clr_err",   32'(err),    32'd0);
        check("to_clr_st",    32'(state),  32'd0);
        step(1);
        check("to_restart",   32'(state),  32'd1);
        pll_req = 1'b0;
        step(1);
        check("to_wait2",     32'(state),  32'd2);
        step(1);                                    // request dropped in WAIT_LOCK
        check("to_abort",     32'(state),  32'd0);
        check("to_abort_en",  32'(pll_en), 32'd0);
        check("to_abort_err", 32'(err),    32'd0);
`else
        // ---- Retry: first attempt times out, second locks ----
        pll_req = 1'b1;
        step(2);
        check("rt_wait",      32'(state),  32'd2);
        step(64);
        check("rt_drop_st",   32'(state),  32'd1);
        check("rt_drop_en0",  32'(pll_en), 32'd0);
        step(1);
        check("rt_drop_en1",  32'(pll_en), 32'd0);
        step(1);
        check("rt_en_back",   32'(pll_en), 32'd1);
        pll_lock = 1'b1;
        step(1);
        check("rt_wait2",     32'(state),  32'd2);
        step(11);
        check("rt_run",       32'(state),  32'd6);
        check("rt_err",       32'(err),    32'd0);
        pll_req = 1'b0;
        step(7);
        check("rt_idle",      32'(state),  32'd0);
        pll_lock = 1'b0;
        step(2);
`endif

        // ---- Lock glitch: 2 high, 1 low, then steady ----
        pll_req = 1'b1;
        step(2);                                    // H2: WAIT_LOCK
        check("gl_wait",      32'(state),  32'd2);
        pll_lock = 1'b1;
        step(2);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;                            // steady rise on lock_s at H7
        pll_req  = 1'b0;                            // dropped in WAIT_LOCK would abort...
        pll_req  = 1'b1;                            // ...so keep it high here
        step(5);                                    // H10
        check("gl_wait_h10",  32'(state),  32'd2);
        step(1);                                    // H11
        check("gl_goff",      32'(state),  32'd3);
        pll_req = 1'b0;                             // ignored during the switch
        step(6);                                    // H17
        check("gl_run",       32'(state),  32'd6);
        step(1);
        check("gl_leave",     32'(state),  32'd3);
        step(6);
        check("gl_idle",      32'(state),  32'd0);
        check("gl_err",       32'(err),    32'd0);

        // ---- Reset mid-sequence while PLL is selected ----
        pll_req = 1'b1;
        step(8);                                    // PLL_ON, WAIT_LOCK x4, GATE_OFF x2
        check("mr_sw",        32'(state),  32'd4);
        check("mr_sw_sel",    32'(clk_sel), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mr_state",     32'(state),  32'd0);
        check("mr_sel",       32'(clk_sel), 32'd0);
        check("mr_gate",      32'(gate_en), 32'd1);
        check("mr_pll_en",    32'(pll_en), 32'd0);
        check("mr_dom",       32'(dom_rst), 32'd0);
        pll_req = 1'b0;
        step(1);
        rst = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
